muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit that executes the operations the ALU flags with `aluop[6]` but does not implement itself. It accepts one operation at a time from the execute stage, runs a 32-step shift-add (multiply) or restoring (divide) sequence, and returns a 32-bit result with a one-cycle `done` pulse. While an operation is in flight, `busy` stalls the pipeline.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported; the counter is sized for 32 steps.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `kill` input 1: synchronous flush of the current operation.
- `funct3` input 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input 32: rs1 operand; the dividend for divide operations.
- `b` input 32: rs2 operand; the divisor for divide operations.
- `busy` output 1: high in CALC or FIX.
- `done` output 1: high only in DONE, for one cycle.
- `result` output 32: registered result. Valid while `done`=1 and held until the next accepted start.

## Operation
- **Reset:** state=IDLE; `busy`=0; `done`=0; `result`=0; step counter=0. All internal registers are cleared.
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE, `start`=1 and `kill`=0:**
  - Latch `funct3`, the operand signs and the operand magnitudes.
  - Signed view applies to: `a` for MULH, MULHSU, DIV, REM; `b` for MULH, DIV, REM. All other operands are unsigned.
  - Special cases go straight to DONE with the final `result`:
    - Divide by zero (`b`=0, funct3[2]=1): DIV/DIVU give 0xFFFFFFFF; REM/REMU give `a`.
    - Signed overflow (DIV/REM, `a`=0x80000000, `b`=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC with counter=0.
- **CALC:** one step per cycle; 32 steps, counter 0..31; after step 31, go to FIX.
  - Multiply: 64-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: shift the remainder left and bring in the next dividend bit. Subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit to 1.
- **FIX:** apply signs, select the output word, load `result`, go to DONE.
  - Product negated if the signed-view signs differ.
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- **DONE:** `done`=1; next edge goes to IDLE. `start` is ignored in DONE.
- **`kill`=1:** from any state, next edge goes to IDLE.
  - `done` is not asserted for the killed operation; `result` keeps its old value.
  - `kill` and `start` together in IDLE: `kill` wins and nothing is accepted.
- `start` in CALC or FIX is ignored. The requester must hold off while `busy`=1.
- All arithmetic is modulo 2^32 (2^64 for the product). Negation is two's complement, so magnitude(0x80000000) = 0x80000000 as unsigned.

## Timing
- Normal path, with `start` accepted at edge E:
  - CALC steps at edges E+1..E+32.
  - FIX at edge E+33.
  - `done`/`result` valid in the cycle after edge E+33, a latency of 34 cycles.
  - Back in IDLE after edge E+34; the next start is accepted at edge E+35 at the earliest.
- Special-case path: `done` is high in the cycle after edge E (latency 1) and the unit is back in IDLE after E+1.
- `busy` rises in the cycle after the accept edge and falls when DONE is entered. `busy` and `done` are never high together.
- Reset mid-operation: the unit is immediately in IDLE, with all outputs at their reset values and no `done`.

## Test plan
- **MUL** `a`=7, `b`=0xFFFFFFFD (-3) → `result`=0xFFFFFFEB; `done` exactly 34 cycles after the accept edge; `busy` high for 33 cycles.
- **High-product variants:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- **Signed division:**
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7%2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE/3 → 0x55555554.
  - REMU 10%3 → 1.
- **Special cases:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5%0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000%-1 → 0.
  - Each special case: `done` in the cycle after the accept edge and `busy` never asserted.
- **Kill:** assert `kill` at CALC step 10 → IDLE next edge, no `done`, `result` unchanged. `kill`+`start` together in IDLE → not accepted. A new start right after the kill completes correctly.
- **Reset:** assert async `reset` mid-CALC between clock edges → `busy`=0, `done`=0, `result`=0 immediately. A `start` held through DONE is not re-accepted until IDLE.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring divide,
// with early completion for divide-by-zero and signed overflow.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic [XLEN-1:0]     mb_q, mb_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                signed_a, signed_b, in_neg_a, in_neg_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                div_by_zero, div_ovf;
   logic [XLEN:0]       mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0]   mul_next, div_next, prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_value;

   always_comb begin
      signed_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
      signed_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      in_neg_a    = signed_a && a[XLEN-1];
      in_neg_b    = signed_b && b[XLEN-1];
      mag_a       = in_neg_a ? (~a + 1'b1) : a;
      mag_b       = in_neg_b ? (~b + 1'b1) : b;
      div_by_zero = funct3[2] && (b == '0);
      div_ovf     = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   end

   // Multiply: accumulate into the upper half, shifting the multiplier out of the lower half.
   // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, mb_q};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end

   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_fix  = neg_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      if (!op_q[2]) begin
         fix_value = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end else begin
         fix_value = op_q[1] ? rem_fix : quo_fix;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      mb_d     = mb_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start && !kill) begin
               op_d    = funct3;
               neg_a_d = in_neg_a;
               neg_b_d = in_neg_b;
               mb_d    = mag_b;
               acc_d   = {{XLEN{1'b0}}, mag_a};
               cnt_d   = '0;
               if (div_by_zero) begin
                  result_d = funct3[1] ? a : '1;
                  state_d  = StDone;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                  state_d  = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StFix;
            end
         end
         StFix: begin
            result_d = fix_value;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // A killed operation never publishes a result.
      if (kill) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         mb_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         mb_q     <= mb_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == StCalc) || (state_q == StFix);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, special cases, kill, reset.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int passed = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation and observe it; lat is the cycle index (1 = cycle after accept) of done.
   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output bit both);
      @(negedge clk);
      funct3 = f;
      a      = x;
      b      = y;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat  = -1;
      bcnt = 0;
      both = 1'b0;
      res  = 32'hDEAD_BEEF;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (busy && done) both = 1'b1;
         if (done) begin
            lat = k;
            res = result;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
      else passed++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
      else passed++;
      checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] res;
      int lat, bcnt;
      bit both;
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, bcnt, both);
      checks++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h expected ffffffeb", res);
      else passed++;
      checks++; if (lat != 34) $display("FAIL mul_latency: got %0d expected 34", lat);
      else passed++;
      checks++; if (bcnt != 33) $display("FAIL mul_busy_cycles: got %0d expected 33", bcnt);
      else passed++;
      checks++; if (both) $display("FAIL mul_busy_done_overlap: got 1 expected 0");
      else passed++;
   endtask

   task automatic test_mul_high();
      logic [2:0]  fv[3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] av[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bv[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
      logic [31:0] ev[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] res;
      int lat, bcnt;
      bit both;
      for (int i = 0; i < 3; i++) begin
         issue(fv[i], av[i], bv[i], res, lat, bcnt, both);
         checks++;
         if (res !== ev[i]) $display("FAIL mul_high_%0d: got %h expected %h", i, res, ev[i]);
         else passed++;
         checks++;
         if (lat != 34) $display("FAIL mul_high_lat_%0d: got %0d expected 34", i, lat);
         else passed++;
      end
   endtask

   task automatic test_div();
      logic [2:0]  fv[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] av[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd10};
      logic [31:0] bv[4] = '{32'd2, 32'd2, 32'd3, 32'd3};
      logic [31:0] ev[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h5555_5554, 32'd1};
      logic [31:0] res;
      int lat, bcnt;
      bit both;
      for (int i = 0; i < 4; i++) begin
         issue(fv[i], av[i], bv[i], res, lat, bcnt, both);
         checks++;
         if (res !== ev[i]) $display("FAIL div_%0d: got %h expected %h", i, res, ev[i]);
         else passed++;
         checks++;
         if (lat != 34) $display("FAIL div_lat_%0d: got %0d expected 34", i, lat);
         else passed++;
      end
   endtask

   task automatic test_special();
      logic [2:0]  fv[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] av[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bv[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ev[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [31:0] res;
      int lat, bcnt;
      bit both;
      for (int i = 0; i < 4; i++) begin
         issue(fv[i], av[i], bv[i], res, lat, bcnt, both);
         checks++;
         if (res !== ev[i]) $display("FAIL special_%0d: got %h expected %h", i, res, ev[i]);
         else passed++;
         checks++;
         if (lat != 1) $display("FAIL special_lat_%0d: got %0d expected 1", i, lat);
         else passed++;
         checks++;
         if (bcnt != 0) $display("FAIL special_busy_%0d: got %0d expected 0", i, bcnt);
         else passed++;
      end
   endtask

   task automatic test_kill();
      logic [31:0] res;
      int lat, bcnt, dcnt;
      bit both;
      issue(3'b111, 32'd5, 32'd0, res, lat, bcnt, both);
      checks++; if (res !== 32'd5) $display("FAIL kill_pre_result: got %h expected 5", res);
      else passed++;
      @(negedge clk);
      funct3 = 3'b000;
      a      = 32'd9;
      b      = 32'd9;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL kill_busy: got %b expected 0", busy);
      else passed++;
      checks++; if (done !== 1'b0) $display("FAIL kill_done: got %b expected 0", done);
      else passed++;
      kill = 1'b0;
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      checks++; if (dcnt != 0) $display("FAIL kill_no_done: got %0d done cycles expected 0", dcnt);
      else passed++;
      checks++;
      if (result !== 32'd5) $display("FAIL kill_result_held: got %h expected 5", result);
      else passed++;
      // kill together with start in IDLE must not accept.
      @(negedge clk);
      start = 1'b1;
      kill  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      kill = 1'b0;
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy || done) dcnt++;
      end
      checks++;
      if (dcnt != 0) $display("FAIL kill_start_accepted: got %0d active cycles expected 0", dcnt);
      else passed++;
      issue(3'b101, 32'd100, 32'd7, res, lat, bcnt, both);
      checks++; if (res !== 32'd14) $display("FAIL after_kill_result: got %h expected e", res);
      else passed++;
      checks++; if (lat != 34) $display("FAIL after_kill_lat: got %0d expected 34", lat);
      else passed++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      funct3 = 3'b000;
      a      = 32'd123;
      b      = 32'd456;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy);
      else passed++;
      checks++; if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done);
      else passed++;
      checks++; if (result !== 32'h0) $display("FAIL midreset_result: got %h expected 0", result);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_held_start();
      logic bv[37];
      logic dv[37];
      int lat;
      @(negedge clk);
      funct3 = 3'b000;
      a      = 32'd3;
      b      = 32'd5;
      start  = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         bv[k] = busy;
         dv[k] = done;
      end
      start = 1'b0;
      checks++; if (dv[34] !== 1'b1) $display("FAIL held_done34: got %b expected 1", dv[34]);
      else passed++;
      checks++;
      if (bv[35] !== 1'b0 || dv[35] !== 1'b0)
         $display("FAIL held_idle35: got busy=%b done=%b expected 0 0", bv[35], dv[35]);
      else passed++;
      checks++; if (bv[36] !== 1'b1) $display("FAIL held_reaccept36: got %b expected 1", bv[36]);
      else passed++;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat < 0 || result !== 32'd15)
         $display("FAIL held_second_result: got %h (lat %0d) expected f", result, lat);
      else passed++;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      kill   = 1'b0;
      funct3 = 3'b000;
      a      = '0;
      b      = '0;
      test_reset();
      test_mul();
      test_mul_high();
      test_div();
      test_special();
      test_kill();
      test_reset_mid();
      test_held_start();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
